tick_gen_multi: RTL and testbench
=================================

Name: tick_gen_multi

Overview:
- Parametrised successor of the single-channel clock-enable divider.
- Generates N_CH independent clock-enable channels from clk, each with a run-time programmable divisor.
- Each channel has two outputs: a one-cycle tick pulse and a 50%-style toggle level.
- Sits between the system clock and slow logic (display refresh, debouncers, LED blink); nothing in the design uses a divided clock, only enables.

Parameters:
- N_CH, 4: number of independent channels.
- CNT_W, 28: counter and divisor width in bits.
- DEFAULT_DIV, 62500000: divisor loaded into every channel at reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ch_en  in  N_CH  per-channel run enable.
- sync_clr  in  1  phase-align pulse: restarts all channel counters.
- cfg_valid  in  1  divisor write request.
- cfg_ready  out  1  divisor write may be accepted this cycle.
- cfg_ch  in  $clog2(N_CH) (min 1)  target channel.
- cfg_div  in  CNT_W  new divisor.
- cfg_err  out  1  one-cycle pulse: accepted write had an out-of-range cfg_ch.
- tick  out  N_CH  registered one-cycle enable pulse per channel.
- level  out  N_CH  registered toggle output per channel.

Behaviour:
- Reset: per channel, div_r=DEFAULT_DIV, cnt=0, pending=0, tick=0, level=0; cfg_err=0. cfg_ready reads 1 in the first cycle after reset.
- Counting, per channel, when ch_en=1, div_r!=0 and sync_clr=0:
  - If cnt==div_r-1: cnt<=0, tick<=1, level<=~level.
  - Else: cnt<=cnt+1, tick<=0.
- Period: tick period = div_r cycles; level period = 2*div_r cycles.
- First tick after enable: tick rises exactly div_r cycles after the first cycle ch_en=1 is sampled.
- div_r=1: tick is high every cycle; level toggles every cycle.
- div_r=0: channel halted. cnt held at 0, tick=0, level held.
- ch_en=0: cnt<=0, tick<=0, level holds its value.
- sync_clr=1: all channels cnt<=0, tick<=0, level<=0. It overrides terminal count and any pending apply in that cycle.
- Config handshake:
  - cfg_ready = ~pending[cfg_ch] when cfg_ch<N_CH, else 1.
  - A write is accepted when cfg_valid && cfg_ready.
  - On acceptance with an in-range channel: cfg_div is loaded into shadow[cfg_ch] and pending is set.
  - On acceptance with cfg_ch>=N_CH: the write is dropped and cfg_err pulses high the next cycle.
- Applying a pending divisor:
  - Channel running (ch_en=1, div_r!=0): applied at that channel's next terminal count. div_r<=shadow, pending<=0, and the tick of that terminal still fires. The new period starts from the next cycle.
  - Channel disabled or halted: applied on the cycle after acceptance.
  - sync_clr active: applied on the cycle after sync_clr.
- Acceptance coinciding with terminal count: shadow loads, and the apply waits for the following terminal. This is glitch-free and never shortens a period.
- No arithmetic overflow: cnt never exceeds div_r-1 <= 2^CNT_W-2; div_r=2^CNT_W-1 is legal.
- Reset mid-operation discards shadow and pending values and returns to reset state.

Decomposition:
- Package tick_gen_pkg holds:
  - CNT_W_DEF and DEFAULT_DIV_DEF constants.
  - typedef div_t = logic [CNT_W-1:0].
  - Constant DIV_HALT=0.
- Sub-module tick_chan: one channel containing cnt, div_r, shadow, pending, tick and level.
  - Ports: clk, rst, en, sync_clr, wr, wr_div, pending, tick, level.
  - Instantiated N_CH times in a generate loop.
- The top level holds cfg decode, cfg_ready mux and cfg_err.

Test Plan:
- Bench config for all scenarios: CNT_W=8, DEFAULT_DIV=5.
- Reset release with ch_en=4'b0001: tick[0] at cycles 5, 10, 15 after enable; level[0] toggles at each; tick[3:1]=0, level[3:1]=0.
- While ch0 runs at div 5, write cfg_ch=0, cfg_div=3 at cnt=2 -> cfg_ready[ch0] drops; the current 5-cycle period completes; subsequent ticks are 3 apart; cfg_ready returns to 1 after the apply cycle.
- Write cfg_div=1 to ch1 while disabled, then enable -> tick[1] high every cycle; level[1] alternates 0,1,0,1.
- Write cfg_div=0 to ch2 while running -> after its next terminal, tick[2] stays 0 and level[2] frozen; then write 4 -> ticks resume 4 cycles after the apply.
- All channels running at div 5 with staggered enables, then pulse sync_clr -> all level=0, and all tick coincide 5 cycles later. Hold ch_en[3]=0 for 3 cycles -> level[3] holds, and the next tick comes 5 cycles after re-enable.
- Write cfg_ch=5 (with N_CH=4 and a 3-bit cfg_ch override) -> accepted, cfg_err pulses 1 cycle, no channel divisor changes. Assert rst mid-period -> all outputs 0 the next cycle and div_r back to 5.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared constants and types for the multi-channel tick generator
package tick_gen_pkg;
  localparam int CNT_W_DEF = 28;
  localparam int DEFAULT_DIV_DEF = 62500000;
  typedef logic [CNT_W_DEF-1:0] div_t;
  localparam div_t DIV_HALT = '0;
endpackage

// File: rtl/tick_chan.sv
// tick_chan: one clock-enable channel with shadowed divisor and glitch-free apply
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             pending,
  output logic             tick,
  output logic             level
);
  logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, shadow_q, shadow_d;
  logic pend_q, pend_d, tick_q, tick_d, level_q, level_d, sclr_q;
  logic run, term, apply;
  // Count, detect terminal, and decide when the shadow divisor takes effect.
  // Any apply restarts the period so cnt never exceeds the new div_r-1.
  always_comb begin
    run = en && div_q != CNT_W'(DIV_HALT);
    term = run && !sync_clr && cnt_q == div_q - CNT_W'(1);
    apply = pend_q && !sync_clr && (!run || term || sclr_q);
    cnt_d = (sync_clr || !run || term || apply) ? '0 : cnt_q + CNT_W'(1);
    tick_d = term;
    level_d = sync_clr ? 1'b0 : level_q ^ term;
    div_d = apply ? shadow_q : div_q;
    shadow_d = wr ? wr_div : shadow_q;
    pend_d = wr || (pend_q && !apply);
  end
  // Channel state registers; reset discards any shadowed divisor.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      div_q <= CNT_W'(DEFAULT_DIV);
      shadow_q <= CNT_W'(DEFAULT_DIV);
      pend_q <= 1'b0;
      tick_q <= 1'b0;
      level_q <= 1'b0;
      sclr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      shadow_q <= shadow_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      level_q <= level_d;
      sclr_q <= sync_clr;
    end
  end
  assign pending = pend_q;
  assign tick = tick_q;
  assign level = level_q;
endmodule

// File: rtl/tick_gen_multi.sv
// tick_gen_multi: N_CH programmable clock-enable channels with a shared config port
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
  parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             sync_clr,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_err,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  level
);
  logic [N_CH-1:0] pending, wr;
  logic [(1<<CH_W)-1:0] pend_x;
  logic in_range, accept, cfg_err_d, cfg_err_q;
  // Ready mux over the addressed channel; out-of-range writes are always taken and flagged.
  always_comb begin
    pend_x = '0;
    pend_x[N_CH-1:0] = pending;
    in_range = int'(cfg_ch) < N_CH;
    cfg_ready = in_range ? !pend_x[cfg_ch] : 1'b1;
    accept = cfg_valid && cfg_ready;
    cfg_err_d = accept && !in_range;
  end
  // One-cycle error pulse after a dropped write.
  always_ff @(posedge clk) begin
    if (rst) cfg_err_q <= 1'b0;
    else cfg_err_q <= cfg_err_d;
  end
  assign cfg_err = cfg_err_q;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign wr[i] = accept && int'(cfg_ch) == i;
    tick_chan #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_chan (
      .clk(clk),
      .rst(rst),
      .en(ch_en[i]),
      .sync_clr(sync_clr),
      .wr(wr[i]),
      .wr_div(cfg_div),
      .pending(pending[i]),
      .tick(tick[i]),
      .level(level[i])
    );
  end
endmodule

// File: tb/tb_tick_gen_multi.sv
// tb_tick_gen_multi: directed scenarios plus randomized run against a behavioural model
module tb_tick_gen_multi;
  logic clk = 1'b0, rst = 1'b1, sync_clr = 1'b0, cfg_valid = 1'b0;
  logic cfg_ready, cfg_err;
  logic [3:0] ch_en = '0, tick, level;
  logic [2:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  tick_gen_multi #(.N_CH(4), .CNT_W(8), .DEFAULT_DIV(5), .CH_W(3)) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .sync_clr(sync_clr),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_err(cfg_err), .tick(tick), .level(level)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ch_en = '0; sync_clr = 1'b0; cfg_valid = 1'b0; cfg_ch = '0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; ch_en = 4'hF; sync_clr = 1'b0; cfg_valid = 1'b0; cfg_ch = '0;
    step();
    step();
    n_cmp++;
    if ({tick, level, cfg_err, cfg_ready} !== 10'b0000_0000_0_1) begin
      n_bad++;
      $display("FAIL reset: tick=%b level=%b err=%b ready=%b, want 0000 0000 0 1", tick, level, cfg_err, cfg_ready);
    end
  endtask

  task automatic test_basic();
    logic exp_t, exp_l;
    do_reset();
    rst = 1'b0; ch_en = 4'b0001;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_t = (k % 5) == 0;
      exp_l = ((k / 5) % 2) == 1;
      n_cmp++;
      if (tick !== {3'b0, exp_t} || level !== {3'b0, exp_l}) begin
        n_bad++;
        $display("FAIL basic k=%0d: tick=%b level=%b, want %b %b", k, tick, level, {3'b0, exp_t}, {3'b0, exp_l});
      end
    end
  endtask

  task automatic test_div_change();
    logic exp_t;
    do_reset();
    rst = 1'b0; ch_en = 4'b0001; cfg_ch = 3'd0; cfg_div = 8'd3;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k >= 2) begin
        n_cmp++;
        if (cfg_ready !== (k == 2 || k >= 5)) begin
          n_bad++;
          $display("FAIL div_change ready k=%0d: got %b want %b", k, cfg_ready, (k == 2 || k >= 5));
        end
      end
      if (k == 2) cfg_valid = 1'b1;
      if (k == 3) cfg_valid = 1'b0;
      exp_t = k == 5 || (k > 5 && (k - 5) % 3 == 0);
      n_cmp++;
      if (tick[0] !== exp_t) begin
        n_bad++;
        $display("FAIL div_change tick k=%0d: got %b want %b", k, tick[0], exp_t);
      end
    end
  endtask

  task automatic test_div_one();
    logic exp_t, exp_l;
    do_reset();
    rst = 1'b0; cfg_ch = 3'd1; cfg_div = 8'd1; cfg_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) cfg_valid = 1'b0;
      exp_t = k >= 3;
      exp_l = k >= 3 && (k - 3) % 2 == 0;
      n_cmp++;
      if (tick[1] !== exp_t || level[1] !== exp_l) begin
        n_bad++;
        $display("FAIL div_one k=%0d: tick=%b level=%b, want %b %b", k, tick[1], level[1], exp_t, exp_l);
      end
      if (k == 2) ch_en = 4'b0010;
    end
  endtask

  task automatic test_halt();
    logic exp_t, exp_l;
    do_reset();
    rst = 1'b0; ch_en = 4'b0100; cfg_ch = 3'd2; cfg_div = 8'd0; cfg_valid = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      step();
      if (k == 1) cfg_valid = 1'b0;
      if (k == 9) begin cfg_div = 8'd4; cfg_valid = 1'b1; end
      if (k == 10) cfg_valid = 1'b0;
      exp_t = k == 5 || k == 15 || k == 19;
      exp_l = (k >= 5 && k < 15) || k >= 19;
      n_cmp++;
      if (tick[2] !== exp_t || level[2] !== exp_l) begin
        n_bad++;
        $display("FAIL halt k=%0d: tick=%b level=%b, want %b %b", k, tick[2], level[2], exp_t, exp_l);
      end
    end
  endtask

  task automatic test_sync_clr();
    do_reset();
    rst = 1'b0; ch_en = 4'b0001;
    for (int k = 1; k <= 26; k++) begin
      step();
      if (k == 13) begin
        n_cmp++;
        if (tick !== 4'h0 || level !== 4'h0) begin
          n_bad++;
          $display("FAIL sync_clr clear: tick=%b level=%b, want 0000 0000", tick, level);
        end
      end
      if (k >= 14 && k <= 18) begin
        n_cmp++;
        if (tick !== (k == 18 ? 4'hF : 4'h0)) begin
          n_bad++;
          $display("FAIL sync_clr align k=%0d: tick=%b want %b", k, tick, (k == 18 ? 4'hF : 4'h0));
        end
      end
      if (k == 18) begin
        n_cmp++;
        if (level !== 4'hF) begin
          n_bad++;
          $display("FAIL sync_clr level: got %b want 1111", level);
        end
      end
      if (k >= 19 && k <= 21) begin
        n_cmp++;
        if (level[3] !== 1'b1 || tick[3] !== 1'b0) begin
          n_bad++;
          $display("FAIL hold k=%0d: tick3=%b level3=%b, want 0 1", k, tick[3], level[3]);
        end
      end
      if (k >= 22) begin
        n_cmp++;
        if (tick[3] !== (k == 26)) begin
          n_bad++;
          $display("FAIL reenable k=%0d: tick3=%b want %b", k, tick[3], (k == 26));
        end
      end
      if (k == 1) ch_en = 4'b0011;
      if (k == 2) ch_en = 4'b0111;
      if (k == 3) ch_en = 4'b1111;
      if (k == 12) sync_clr = 1'b1;
      if (k == 13) sync_clr = 1'b0;
      if (k == 18) ch_en = 4'b0111;
      if (k == 21) ch_en = 4'b1111;
    end
  endtask

  task automatic test_cfg_err_rst();
    do_reset();
    rst = 1'b0; ch_en = 4'b0001; cfg_ch = 3'd5; cfg_div = 8'd2;
    #1;
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL oor_ready: got %b want 1", cfg_ready);
    end
    cfg_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) begin
        n_cmp++;
        if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL cfg_err pulse: got %b want 1", cfg_err); end
        cfg_ch = 3'd0;
      end
      if (k == 2) begin
        n_cmp++;
        if (cfg_err !== 1'b0 || cfg_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL cfg_err end: err=%b ready=%b, want 0 0", cfg_err, cfg_ready);
        end
        cfg_valid = 1'b0;
      end
      if (k == 5) begin
        n_cmp++;
        if (tick !== 4'b0001 || level !== 4'b0001) begin
          n_bad++;
          $display("FAIL oor_nochange: tick=%b level=%b, want 0001 0001", tick, level);
        end
      end
      if (k == 6) rst = 1'b1;
      if (k == 7) begin
        n_cmp++;
        if ({tick, level, cfg_err, cfg_ready} !== 10'b0000_0000_0_1) begin
          n_bad++;
          $display("FAIL mid_reset: tick=%b level=%b err=%b ready=%b, want 0000 0000 0 1", tick, level, cfg_err, cfg_ready);
        end
        rst = 1'b0;
      end
      if (k >= 8) begin
        n_cmp++;
        if (tick[0] !== (k == 12)) begin
          n_bad++;
          $display("FAIL post_reset_div k=%0d: tick0=%b want %b", k, tick[0], (k == 12));
        end
      end
    end
  endtask

  // Model: each channel remembers the cycle its current period started;
  // the terminal cycle is start + div - 1.
  task automatic test_random();
    int m_div[4], m_sh[4], m_start[4];
    bit m_pend[4], m_tick[4], m_lvl[4];
    bit m_err, m_sprev, acc, m_rdy, run, term, app;
    logic [3:0] e_tick, e_lvl;
    int cyc, ch;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      m_div[c] = 5; m_sh[c] = 5; m_start[c] = 0;
      m_pend[c] = 0; m_tick[c] = 0; m_lvl[c] = 0;
    end
    m_err = 0; m_sprev = 0; cyc = 0;
    rst = 1'b0; ch_en = 4'hF;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(9) == 0) ch_en[2'($urandom_range(3))] ^= 1'b1;
      sync_clr = $urandom_range(39) == 0;
      cfg_valid = $urandom_range(2) == 0;
      cfg_ch = 3'($urandom_range(5));
      cfg_div = 8'($urandom_range(6));
      #1;
      ch = int'(cfg_ch);
      m_rdy = ch < 4 ? !m_pend[ch] : 1'b1;
      n_cmp++;
      if (cfg_ready !== m_rdy) begin
        n_bad++;
        $display("FAIL rand ready n=%0d ch=%0d: got %b want %b", n, ch, cfg_ready, m_rdy);
      end
      acc = cfg_valid && m_rdy;
      for (int c = 0; c < 4; c++) begin
        run = ch_en[c] && m_div[c] != 0;
        term = run && !sync_clr && (cyc - m_start[c] == m_div[c] - 1);
        app = m_pend[c] && !sync_clr && (!run || term || m_sprev);
        m_tick[c] = term;
        m_lvl[c] = sync_clr ? 1'b0 : m_lvl[c] ^ term;
        if (sync_clr || !run || term || app) m_start[c] = cyc + 1;
        if (app) begin m_div[c] = m_sh[c]; m_pend[c] = 0; end
        if (acc && ch == c) begin m_sh[c] = int'(cfg_div); m_pend[c] = 1; end
      end
      m_err = acc && ch >= 4;
      m_sprev = sync_clr;
      cyc++;
      step();
      for (int c = 0; c < 4; c++) begin e_tick[c] = m_tick[c]; e_lvl[c] = m_lvl[c]; end
      n_cmp++;
      if (tick !== e_tick || level !== e_lvl || cfg_err !== m_err) begin
        n_bad++;
        $display("FAIL rand out n=%0d: tick=%b level=%b err=%b, want %b %b %b", n, tick, level, cfg_err, e_tick, e_lvl, m_err);
      end
    end
    sync_clr = 1'b0; cfg_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_change();
    test_div_one();
    test_halt();
    test_sync_clr();
    test_cfg_err_rst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete within 500000 time units");
    $fatal(1);
  end
endmodule
